// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Multi-cycle data-memory target for the load/store handshake.
//            Fixed access latency, one Ack pulse per request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req,
    input  logic              We,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic              Ack,
    output logic [DATA_W-1:0] RdData,
    output logic              Err,
    output logic              Busy
);

    localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        CNT_INIT   = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                resp_go;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [IDX_W-1:0]    acc_idx;
    logic                acc_in_range;

    // With LATENCY=1 the response is formed on the acceptance edge itself,
    // so the live request fields are used instead of the latched copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = We;
            acc_addr  = Addr;
            acc_wdata = WrData;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_in_range = (acc_addr < ADDR_LIMIT);
        acc_idx      = acc_addr[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        mem_d   = mem_q;
        resp_go = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    we_d    = We;
                    addr_d  = Addr;
                    wdata_d = WrData;
                    busy_d  = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        resp_go = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    resp_go = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Range check at full address width; the index is only used once the
        // address is known to be inside the array, so no aliasing occurs.
        if (resp_go) begin
            ack_d = 1'b1;
            if (acc_in_range) begin
                if (acc_we) begin
                    mem_d[acc_idx] = acc_wdata;
                end else begin
                    rdata_d = mem_q[acc_idx];
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            mem_q   <= mem_d;
        end
    end

    assign Ack    = ack_q;
    assign RdData = rdata_q;
    assign Err    = err_q;
    assign Busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Directed bench for data_mem_responder (LATENCY=2 and LATENCY=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic        ack, err, busy;
    logic [15:0] rdata;
    logic        req1, we1;
    logic [15:0] addr1, wdata1;
    logic        ack1, err1, busy1;
    logic [15:0] rdata1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .LATENCY(2)) u_dut (
        .Clock(clk), .Reset(rst), .Req(req), .We(we), .Addr(addr), .WrData(wdata),
        .Ack(ack), .RdData(rdata), .Err(err), .Busy(busy)
    );

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .LATENCY(1)) u_dut1 (
        .Clock(clk), .Reset(rst), .Req(req1), .We(we1), .Addr(addr1), .WrData(wdata1),
        .Ack(ack1), .RdData(rdata1), .Err(err1), .Busy(busy1)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full LATENCY=2 transaction with the requester dropping Req after Ack.
    task automatic txn(input vec_t v, input string name);
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
        @(posedge clk); #1;
        check({name, "_busy_e0"}, busy, 1);
        check({name, "_ack_e0"},  ack,  0);
        @(posedge clk); #1;
        check({name, "_ack"},   ack,   1);
        check({name, "_rdata"}, rdata, v.exp_rd);
        check({name, "_err"},   err,   v.exp_err);
        check({name, "_busy"},  busy,  1);
        @(posedge clk); #1;
        check({name, "_ack_end"},  ack,  0);
        check({name, "_busy_end"}, busy, 0);
        req = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h0005, 16'h0000, 16'h0005, 1'b0};
        vecs[1]  = '{1'b1, 16'h0003, 16'h00AB, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0003, 16'h0000, 16'h00AB, 1'b0};
        vecs[3]  = '{1'b0, 16'h0002, 16'h0000, 16'h0002, 1'b0};
        vecs[4]  = '{1'b0, 16'h0004, 16'h0000, 16'h0004, 1'b0};
        vecs[5]  = '{1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 16'h0008, 16'h5555, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 16'hFFFF, 16'h1111, 16'h0000, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 16'h0007, 16'h0000, 16'h0007, 1'b0};
        vecs[10] = '{1'b1, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};

        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("rst_ack",    ack,    0);
        check("rst_busy",   busy,   0);
        check("rst_rdata",  rdata,  0);
        check("rst_err",    err,    0);
        check("rst1_ack",   ack1,   0);
        check("rst1_busy",  busy1,  0);

        for (int i = 0; i < 12; i++) begin
            txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Req held high: new acceptance every 3 edges; Addr moved during WAIT.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0001;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_ack_k%0d", k), ack, (k % 3 == 1));
            if (k % 3 == 1) check($sformatf("hold_rdata_k%0d", k), rdata, 16'h0001);
            @(negedge clk);
            addr = (k % 3 == 0) ? 16'h0006 : 16'h0001;
        end
        req = 1'b0;

        // Reset during WAIT aborts a store.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0002; wdata = 16'h1234;
        @(posedge clk); #1;
        check("abort_busy_e0", busy, 1);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_ack",  ack,  0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ack_after", ack, 0);
        txn('{1'b0, 16'h0002, 16'h0000, 16'h0002, 1'b0}, "abort_ld2");
        txn('{1'b0, 16'h0003, 16'h0000, 16'h0003, 1'b0}, "reinit_ld3");

        // LATENCY=1 instance: Ack on the edge after acceptance, every 2 cycles.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0007;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat1_ack_k%0d", k),  ack1,  (k % 2 == 0));
            check($sformatf("lat1_busy_k%0d", k), busy1, (k % 2 == 0));
            if (k % 2 == 0) begin
                check($sformatf("lat1_rdata_k%0d", k), rdata1, 16'h0007);
                check($sformatf("lat1_err_k%0d", k),   err1,   0);
            end
        end
        @(negedge clk); req1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the processor's load/store interface.
- The processor's ld/sd sequencing raises a request with address, direction and write data, then waits for Ack.
- This block holds the data-memory array, applies a fixed programmable access latency, and answers every request with exactly one Ack pulse carrying read data or an error flag.
- Replaces the processor-internal data array once ld/sd move to the handshake.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, request address width (processor register width).
- DEPTH, 8, number of words implemented; valid addresses 0..DEPTH-1.
- LATENCY, 2, clock edges from Req acceptance to Ack assertion; legal range 1..15.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  request valid; held high by the requester until Ack is seen.
- We  in  1  1 = store (sd), 0 = load (ld); sampled with Req.
- Addr  in  ADDR_W  word address; sampled with Req.
- WrData  in  DATA_W  store data; sampled with Req.
- Ack  out  1  one-cycle response strobe.
- RdData  out  DATA_W  load result; valid only while Ack=1.
- Err  out  1  address out of range; valid only while Ack=1.
- Busy  out  1  high whenever a request is accepted and not yet acknowledged.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (edge with Reset=1): state=IDLE; Ack=0, Err=0, Busy=0, RdData=0; latched request fields cleared; mem[i]=i for i=0..DEPTH-1. Reset overrides Req in the same edge.
- IDLE: on an edge with Req=1, latch We/Addr/WrData and set Busy=1. Call this edge E0.
  - If LATENCY=1, go to RESP.
  - Otherwise go to WAIT with the countdown loaded with LATENCY-1.
- WAIT: decrement the countdown each edge. When it reaches 1, the next edge (E0+LATENCY-1) moves to RESP. Req/We/Addr/WrData changes during WAIT are ignored; only the latched copy is used.
- Entry into RESP (edge E0+LATENCY-1): Ack, RdData and Err are registered on this edge.
  - Valid load: RdData=mem[Addr], Err=0.
  - Valid store: mem[Addr]=WrData is written on this edge, RdData=0, Err=0.
  - Addr>=DEPTH: no memory write, RdData=0, Err=1. The upper address bits are never truncated to alias into the array.
- Response visibility: Ack=1 for exactly the one cycle after edge E0+LATENCY-1.
- RESP: the next edge (E0+LATENCY) clears Ack/Err/RdData/Busy and returns to IDLE. Req is not sampled on this edge.
- Requester rule: sample Ack=1 at edge E0+LATENCY, then drop Req. If Req is still high at edge E0+LATENCY+1, it is taken as a new, independent request.
- Throughput: at most one transaction per LATENCY+1 cycles; no pipelining or queueing.
- Store then immediate load to the same address returns the stored value (write commits before the next acceptance).
- Reset mid-transaction (WAIT or RESP): abort, no Ack for the aborted request, a store not yet committed is lost, memory is reinitialised.
- Widths: the compare Addr<DEPTH is done at full ADDR_W width. The array index is taken from the low clog2(DEPTH) bits only after the range check.

Test Plan:
- Reset, then load Addr=5 (LATENCY=2): Req sampled at E0; Ack=1, RdData=5, Err=0 during exactly one cycle after E0+1; Busy=1 from E0 until E0+2.
- Store Addr=3 WrData=16'h00AB, then load Addr=3: store Ack has RdData=0; the following load returns 16'h00AB; mem[2] and mem[4] remain 2 and 4.
- Load Addr=16'h0008 and store Addr=16'hFFFF: Ack with Err=1, RdData=0; a subsequent load of Addr=0 still returns 0 (no aliasing writes).
- Req held high continuously with Addr=1: Acks repeat every LATENCY+1=3 cycles, each with RdData=1; Addr changed to 6 during WAIT does not affect the current response.
- Store Addr=2 WrData=16'h1234 with Reset pulsed during WAIT: no Ack; Busy=0 after the reset edge; a following load of Addr=2 returns 2.
- LATENCY=1 build: load Addr=7 sampled at E0 gives Ack high in the next cycle with RdData=7; back-to-back requests complete every 2 cycles.
